// File: rtl/addsub_pkg.sv
// Shared definitions for the 16-bit add/subtract unit, its golden model and
// its result checker.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PASSING = 2'd1,
    FAILED  = 2'd2
  } chk_state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/addsub_result_checker_ref_model.sv
// Combinational golden add/subtract: {cout, sum} = a + b, or a + ~b + 1.
// Subtract carry-out is the inverted borrow (1 means a >= b).
module addsub_ref_model
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             as,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total_s;

  // Widened add so the carry falls out as the top bit.
  always_comb begin
    total_s = '0;
    if (as == OP_SUB) begin
      total_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      total_s = {1'b0, a} + {1'b0, b};
    end
  end

  assign {cout, sum} = total_s;

endmodule

// File: rtl/addsub_result_checker.sv
// Response-side checker: carries the reference-model expectation down a
// LATENCY-deep delay line and compares it against the adder's sum/cout.
module addsub_result_checker
  import addsub_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int WIDTH   = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             as,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             clr_stats,
  output logic             chk_valid,
  output logic             pass,
  output logic             err_sticky,
  output logic [15:0]      txn_count,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_as,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout
);

  typedef struct packed {
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             as;
  } stage_t;

  logic [WIDTH-1:0]   ref_sum_s;
  logic               ref_cout_s;
  logic [LATENCY-1:0] vld_r;
  stage_t             line_r [LATENCY];
  stage_t             tail_s;
  logic               done_s;
  logic               mismatch_s;
  chk_state_t         state_r;

  addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a    (a),
    .b    (b),
    .as   (as),
    .sum  (ref_sum_s),
    .cout (ref_cout_s)
  );

  // Valid bits are the only delay-line state reset touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= '0;
    end else begin
      vld_r[0] <= op_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Expectation and operand payload shift every cycle.
  always_ff @(posedge clk) begin
    line_r[0] <= '{exp_sum: ref_sum_s, exp_cout: ref_cout_s, a: a, b: b, as: as};
    for (int i = 1; i < LATENCY; i++) begin
      line_r[i] <= line_r[i-1];
    end
  end

  // Compare the oldest stage against what the adder presents now.
  always_comb begin
    tail_s     = line_r[LATENCY-1];
    done_s     = vld_r[LATENCY-1];
    mismatch_s = 1'b0;
    if (done_s) begin
      mismatch_s = (sum != tail_s.exp_sum) || (cout != tail_s.exp_cout);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Result pulse, statistics, state machine and first-failure capture.
  // A clear in the same cycle as a completion wins over the update.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid <= 1'b0;
      pass      <= 1'b0;
      txn_count <= 16'd0;
      err_count <= 16'd0;
      state_r   <= EMPTY;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_as   <= 1'b0;
      fail_sum  <= '0;
      fail_cout <= 1'b0;
    end else begin
      chk_valid <= done_s;
      pass      <= done_s && !mismatch_s;
      if (clr_stats) begin
        txn_count <= 16'd0;
        err_count <= 16'd0;
        state_r   <= EMPTY;
        fail_a    <= '0;
        fail_b    <= '0;
        fail_as   <= 1'b0;
        fail_sum  <= '0;
        fail_cout <= 1'b0;
      end else if (done_s) begin
        txn_count <= sat_inc(txn_count);
        if (mismatch_s) begin
          err_count <= sat_inc(err_count);
          state_r   <= FAILED;
          if (state_r != FAILED) begin
            fail_a    <= tail_s.a;
            fail_b    <= tail_s.b;
            fail_as   <= tail_s.as;
            fail_sum  <= sum;
            fail_cout <= cout;
          end
        end else begin
          case (state_r)
            EMPTY:   state_r <= PASSING;
            PASSING: state_r <= PASSING;
            FAILED:  state_r <= FAILED;
            default: state_r <= EMPTY;
          endcase
        end
      end
    end
  end

  assign err_sticky = (state_r == FAILED);

endmodule

// File: tb/tb_addsub_result_checker.sv
// Bench for addsub_result_checker: two instances (LATENCY 1 and 3) share one
// operand stream; a behavioural adder feeds each, and a scoreboard predicts every output.
module tb_addsub_result_checker;

  localparam int L0 = 1;
  localparam int L1 = 3;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        as;
    logic [15:0] s;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, op_valid, as, clr_stats;
  logic [15:0] a, b;
  logic [15:0] drv_sum;
  logic        drv_cout;

  logic [16:0] pipe        [2][4];
  logic [15:0] sum_i       [2];
  logic        cout_i      [2];
  logic        chk_valid_o [2];
  logic        pass_o      [2];
  logic        sticky_o    [2];
  logic [15:0] txn_o       [2];
  logic [15:0] err_o       [2];
  logic [15:0] fa_o        [2];
  logic [15:0] fb_o        [2];
  logic        fas_o       [2];
  logic [15:0] fsum_o      [2];
  logic        fcout_o     [2];

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // scoreboard: pending transactions indexed by due cycle, plus statistics
  logic        pv    [2][8];
  logic [15:0] pa    [2][8];
  logic [15:0] pb    [2][8];
  logic        pas   [2][8];
  logic [15:0] psum  [2][8];
  logic        pcout [2][8];
  logic        pok   [2][8];
  int          m_txn [2];
  int          m_err [2];
  int          m_st  [2];
  logic [15:0] m_fa [2], m_fb [2], m_fsum [2];
  logic        m_fas [2], m_fcout [2], e_chk [2], e_pass [2];

  always #5 clk = ~clk;

  assign {cout_i[0], sum_i[0]} = pipe[0][L0-1];
  assign {cout_i[1], sum_i[1]} = pipe[1][L1-1];

  addsub_result_checker #(.LATENCY(L0), .WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .a(a), .b(b), .as(as),
    .sum(sum_i[0]), .cout(cout_i[0]), .clr_stats(clr_stats),
    .chk_valid(chk_valid_o[0]), .pass(pass_o[0]), .err_sticky(sticky_o[0]),
    .txn_count(txn_o[0]), .err_count(err_o[0]), .fail_a(fa_o[0]), .fail_b(fb_o[0]),
    .fail_as(fas_o[0]), .fail_sum(fsum_o[0]), .fail_cout(fcout_o[0]));

  addsub_result_checker #(.LATENCY(L1), .WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .a(a), .b(b), .as(as),
    .sum(sum_i[1]), .cout(cout_i[1]), .clr_stats(clr_stats),
    .chk_valid(chk_valid_o[1]), .pass(pass_o[1]), .err_sticky(sticky_o[1]),
    .txn_count(txn_o[1]), .err_count(err_o[1]), .fail_a(fa_o[1]), .fail_b(fb_o[1]),
    .fail_as(fas_o[1]), .fail_sum(fsum_o[1]), .fail_cout(fcout_o[1]));

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic logic [16:0] golden(input logic [15:0] x, input logic [15:0] y, input logic s);
    int unsigned t;
    if (s) t = 32'(x) + 32'd65536 - 32'(y);
    else   t = 32'(x) + 32'(y);
    return t[16:0];
  endfunction

  function automatic void model_clear(input int k);
    m_txn[k] = 0; m_err[k] = 0; m_st[k] = 0;
    m_fa[k] = 16'd0; m_fb[k] = 16'd0; m_fsum[k] = 16'd0; m_fas[k] = 1'b0; m_fcout[k] = 1'b0;
  endfunction

  // what should happen at the edge just taken, given the inputs sampled there
  function automatic void model_edge(input int k);
    int  slot, ds;
    logic done, ok;
    slot = cyc % 8;
    if (reset) begin
      for (int i = 0; i < 8; i++) pv[k][i] = 1'b0;
      model_clear(k);
      e_chk[k] = 1'b0; e_pass[k] = 1'b0;
    end else begin
      done = pv[k][slot];
      ok   = pok[k][slot];
      pv[k][slot] = 1'b0;
      e_chk[k]  = done;
      e_pass[k] = done && ok;
      if (clr_stats) begin
        model_clear(k);
      end else if (done) begin
        if (m_txn[k] < 65535) m_txn[k]++;
        if (!ok) begin
          if (m_err[k] < 65535) m_err[k]++;
          if (m_st[k] != 2) begin
            m_fa[k] = pa[k][slot]; m_fb[k] = pb[k][slot]; m_fas[k] = pas[k][slot];
            m_fsum[k] = psum[k][slot]; m_fcout[k] = pcout[k][slot];
          end
          m_st[k] = 2;
        end else if (m_st[k] == 0) begin
          m_st[k] = 1;
        end
      end
      if (op_valid) begin
        ds = (cyc + lat(k)) % 8;
        pv[k][ds] = 1'b1; pa[k][ds] = a; pb[k][ds] = b; pas[k][ds] = as;
        psum[k][ds] = drv_sum; pcout[k][ds] = drv_cout;
        pok[k][ds] = ({drv_cout, drv_sum} == golden(a, b, as));
      end
    end
  endfunction

  task automatic compare(input int k);
    logic bad;
    nvec++;
    bad = (chk_valid_o[k] !== e_chk[k]) || (pass_o[k] !== e_pass[k]) ||
          (sticky_o[k] !== (m_st[k] == 2)) || (txn_o[k] !== 16'(m_txn[k])) ||
          (err_o[k] !== 16'(m_err[k])) || (fa_o[k] !== m_fa[k]) || (fb_o[k] !== m_fb[k]) ||
          (fas_o[k] !== m_fas[k]) || (fsum_o[k] !== m_fsum[k]) || (fcout_o[k] !== m_fcout[k]);
    if (bad) begin
      nmis++;
      $display("FAIL outputs lat%0d cyc %0d: got chk=%b pass=%b sticky=%b txn=%0d err=%0d fail=%0d/%0d/%b/%0d/%b, need chk=%b pass=%b sticky=%b txn=%0d err=%0d fail=%0d/%0d/%b/%0d/%b",
               lat(k), cyc, chk_valid_o[k], pass_o[k], sticky_o[k], txn_o[k], err_o[k],
               fa_o[k], fb_o[k], fas_o[k], fsum_o[k], fcout_o[k],
               e_chk[k], e_pass[k], (m_st[k] == 2), m_txn[k], m_err[k],
               m_fa[k], m_fb[k], m_fas[k], m_fsum[k], m_fcout[k]);
    end
  endtask

  task automatic hand_check(input string name, input int got, input int need);
    nvec++;
    if (got != need) begin
      nmis++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  // one clock: advance the behavioural adders, the scoreboard, then compare
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
      pipe[k][0] = op_valid ? {drv_cout, drv_sum} : 17'($urandom);
      model_edge(k);
      compare(k);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input logic [15:0] rs, input logic rc);
    op_valid = v; a = x; b = y; as = s; drv_sum = rs; drv_cout = rc;
  endtask

  task automatic drive_good(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [16:0] g;
    g = golden(x, y, s);
    drive(1'b1, x, y, s, g[15:0], g[16]);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t tbl [8];
  int   n, seen;
  logic [16:0] g;

  initial begin
    tbl[0] = '{16'd16,    16'd3,     1'b0, 16'd19,    1'b0};
    tbl[1] = '{16'd33000, 16'd18000, 1'b1, 16'd15000, 1'b1};
    tbl[2] = '{16'd1200,  16'd3,     1'b1, 16'd1197,  1'b1};
    tbl[3] = '{16'd32768, 16'd32768, 1'b1, 16'd0,     1'b1};
    tbl[4] = '{16'd100,   16'd1,     1'b1, 16'd99,    1'b1};
    tbl[5] = '{16'd3,     16'd16,    1'b1, 16'd65523, 1'b0};
    tbl[6] = '{16'd60000, 16'd33000, 1'b0, 16'd27464, 1'b1};
    tbl[7] = '{16'd99,    16'd99,    1'b0, 16'd199,   1'b0};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) pipe[k][i] = 17'd0;
      for (int i = 0; i < 8; i++) begin
        pv[k][i] = 1'b0; pa[k][i] = 16'd0; pb[k][i] = 16'd0; pas[k][i] = 1'b0;
        psum[k][i] = 16'd0; pcout[k][i] = 1'b0; pok[k][i] = 1'b0;
      end
      model_clear(k);
      e_chk[k] = 1'b0; e_pass[k] = 1'b0;
    end
    reset = 1'b1; clr_stats = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    idle(2);

    // known vectors back-to-back; the last one carries an injected sum fault
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].s, tbl[i].c);
      step();
    end
    idle(5);
    hand_check("txn after table", int'(txn_o[0]), 8);
    hand_check("err after fault", int'(err_o[0]), 1);
    hand_check("fail_a", int'(fa_o[0]), 99);
    hand_check("fail_b", int'(fb_o[0]), 99);
    hand_check("fail_sum", int'(fsum_o[0]), 199);
    hand_check("sticky lat3", int'(sticky_o[1]), 1);

    drive(1'b1, 16'd5, 16'd5, 1'b0, 16'd11, 1'b0);
    step();
    idle(5);
    hand_check("err second fault", int'(err_o[0]), 2);
    hand_check("fail_sum kept", int'(fsum_o[0]), 199);

    // clear coincident with a completion; the next in-flight op still checks
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    idle(4);
    drive_good(16'd7, 16'd9, 1'b0); step();
    drive_good(16'd8, 16'd2, 1'b1); clr_stats = 1'b1; step();
    clr_stats = 1'b0; idle(1);
    hand_check("txn after clear", int'(txn_o[0]), 1);
    hand_check("sticky after clear", int'(sticky_o[0]), 0);
    idle(4);

    // reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      drive_good(16'(1000 + i), 16'd1, 1'b0); step();
    end
    reset = 1'b1; idle(1); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (chk_valid_o[0] || chk_valid_o[1]) seen++;
    end
    hand_check("chk after reset", seen, 0);

    // response latency is LATENCY+1 cycles from operand drive
    for (int k = 0; k < 2; k++) begin
      drive_good(16'd1234, 16'd4321, 1'b0);
      n = 0;
      while (n < 10) begin
        step();
        n++;
        drive(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
        if (chk_valid_o[k]) break;
      end
      hand_check(k == 0 ? "latency lat1" : "latency lat3", n, lat(k) + 1);
      idle(4);
    end

    // random traffic with faults, clears and mid-stream resets
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom); as = 1'($urandom);
      g = golden(a, b, as);
      op_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) g[15:0] = g[15:0] ^ (16'd1 << $urandom_range(0, 15));
        else g[16] = ~g[16];
      end
      drv_sum = g[15:0]; drv_cout = g[16];
      clr_stats = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    clr_stats = 1'b0; reset = 1'b0;

    // saturation: more passing transactions than the counter can hold
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    idle(4);
    for (int i = 0; i < 65540; i++) begin
      drive_good(16'($urandom), 16'($urandom), 1'($urandom));
      step();
    end
    idle(5);
    hand_check("txn saturated lat1", int'(txn_o[0]), 65535);
    hand_check("txn saturated lat3", int'(txn_o[1]), 65535);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
